// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
//  arb_state_t : arbiter FSM states (IDLE arbitration cycle, BURST writing)
//  idx_w()     : width of a requester index for n requesters
//  cnt_w()     : width of the beat counter for a given max burst
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  function automatic int unsigned idx_w(int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned cnt_w(int unsigned max_burst);
    return $clog2(max_burst) + 1;
  endfunction

  localparam int unsigned N_REQ_DEF     = 4;
  localparam int unsigned DW_DEF        = 8;
  localparam int unsigned MAX_BURST_DEF = 4;
  localparam int unsigned OWNER_W_DEF   = idx_w(N_REQ_DEF);
  localparam int unsigned CNT_W_DEF     = cnt_w(MAX_BURST_DEF);

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of the producer-side and FIFO-side signals of the arbiter.
//  req/req_data : producer words (slice i of req_data belongs to requester i)
//  gnt          : one-hot, word of requester i consumed this cycle
//  fifo_full    : FIFO full flag
//  fifo_wr/data : FIFO write port
//  owner/busy   : current burst owner and burst-in-progress flag
// Handshake: a requester keeps req[i] high and its slice stable until it
// sees gnt[i]=1; a word is consumed only in a cycle with gnt[i]=1, and the
// next word may be presented in the following cycle.
// Modports: master = arbiter view, slave = producers/FIFO view.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned DW    = DW_DEF
);
  localparam int unsigned OW = idx_w(N_REQ);

  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    gnt;
  logic                fifo_full;
  logic                fifo_wr;
  logic [DW-1:0]       fifo_data;
  logic [OW-1:0]       owner;
  logic                busy;

  modport master (
    input  req, req_data, fifo_full,
    output gnt, fifo_wr, fifo_data, owner, busy
  );

  modport slave (
    output req, req_data, fifo_full,
    input  gnt, fifo_wr, fifo_data, owner, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker (combinational).
//  req   : request vector
//  last  : index of the previous owner; search starts at last+1
//  valid : any request present
//  idx   : first requester found searching last+1 upward with wrap
// The request vector is rotated so last+1 lands at bit 0, the lowest set
// bit is found, and the position is rotated back into a real index.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned OW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [OW-1:0]    last,
  output logic             valid,
  output logic [OW-1:0]    idx
);

  int unsigned            start;
  int unsigned            pos;
  logic [2*N_REQ-1:0]     dbl;
  logic [N_REQ-1:0]       rot;

  always_comb begin
    start = (32'(last) + 32'd1) % N_REQ;
    dbl   = {req, req};
    rot   = N_REQ'(dbl >> start);
    valid = 1'b0;
    pos   = 0;
    // Scan downward so the lowest set bit wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        valid = 1'b1;
        pos   = i;
      end
    end
    idx = OW'((start + pos) % N_REQ);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the single write port of a FIFO between N_REQ producers using
// round-robin arbitration with bursts of up to MAX_BURST words per grant.
//  clk   : rising-edge clock, shared with the FIFO
//  rst   : synchronous active-high reset
//  bus   : producer + FIFO signals (master view)
//  state : FSM state, for observation
// An IDLE cycle arbitrates (no write); BURST writes the owner's words while
// the FIFO is not full. The burst ends after MAX_BURST accepted words or as
// soon as the owner drops req. gnt/fifo_wr are forced low during reset.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = N_REQ_DEF,
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_wr_arbiter_if.master    bus,
  output arb_state_t           state
);

  localparam int unsigned OW = idx_w(N_REQ);
  localparam int unsigned CW = cnt_w(MAX_BURST);

  arb_state_t    state_n;
  logic [OW-1:0] owner_q, owner_n;
  logic [OW-1:0] last_q, last_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          pick_valid;
  logic [OW-1:0] pick_idx;
  logic          accept;

  rr_pick #(.N_REQ(N_REQ), .OW(OW)) u_pick (
    .req   (bus.req),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner_q <= '0;
      last_q  <= OW'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state   <= state_n;
      owner_q <= owner_n;
      last_q  <= last_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    accept        = (state == BURST) & bus.req[owner_q] & ~bus.fifo_full & ~rst;
    state_n       = state;
    owner_n       = owner_q;
    last_n        = last_q;
    cnt_n         = cnt_q;
    bus.fifo_wr   = accept;
    bus.gnt       = accept ? (N_REQ'(1) << owner_q) : '0;
    bus.fifo_data = '0;
    bus.busy      = (state == BURST);
    bus.owner     = owner_q;

    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n = BURST;
          owner_n = pick_idx;
          cnt_n   = '0;
        end
      end
      BURST: begin
        bus.fifo_data = DW'(bus.req_data >> (32'(owner_q) * DW));
        // Full stalls without touching owner/count; a dropped req ends the burst.
        if ((accept && (cnt_q == CW'(MAX_BURST - 1))) || !bus.req[owner_q]) begin
          state_n = IDLE;
          last_n  = owner_q;
        end else if (accept) begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N  = 4;
  localparam int MB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.N_REQ(4), .DW(8)) bus_a ();
  fifo_wr_arbiter_if #(.N_REQ(2), .DW(8)) bus_b ();
  arb_state_t st_a, st_b;

  fifo_wr_arbiter #(.N_REQ(4), .DW(8), .MAX_BURST(4)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.master), .state(st_a));

  fifo_wr_arbiter #(.N_REQ(2), .DW(8), .MAX_BURST(1)) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b.master), .state(st_b));

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks who owns the write port and how many words that owner has
  // written; arbitration searches from the previous owner + 1 with wrap.
  int m_busy, m_owner, m_last, m_beats;
  logic [7:0] exp_q[$];
  logic [3:0] last_gnt;
  logic       last_wr;

  function automatic void model_reset();
    m_busy = 0; m_owner = 0; m_last = N - 1; m_beats = 0;
  endfunction

  function automatic int model_search(input logic [3:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  // One clock cycle on dut_a: drive, check at negedge, advance model.
  task automatic cycle(input logic [3:0] r, input logic [31:0] d, input logic f);
    logic       acc;
    logic [3:0] eg;
    logic [7:0] ed;
    int         pick;
    bus_a.req = r; bus_a.req_data = d; bus_a.fifo_full = f;
    @(negedge clk);
    acc = (m_busy != 0) && r[m_owner] && !f;
    eg  = acc ? 4'(1 << m_owner) : 4'd0;
    ed  = (m_busy != 0) ? d[m_owner*8 +: 8] : 8'd0;
    check("gnt", bus_a.gnt, eg);
    check("fifo_wr", bus_a.fifo_wr, acc);
    check("busy", bus_a.busy, m_busy[0]);
    check("fifo_data", bus_a.fifo_data, ed);
    if (m_busy != 0) check("owner", bus_a.owner, m_owner);
    if (acc) exp_q.push_back(d[m_owner*8 +: 8]);
    if (bus_a.fifo_wr) begin
      if (exp_q.size() == 0) check("sb_unexpected_write", 1, 0);
      else check("sb_data", bus_a.fifo_data, exp_q.pop_front());
    end
    last_gnt = bus_a.gnt;
    last_wr  = bus_a.fifo_wr;
    if (m_busy == 0) begin
      pick = model_search(r);
      if (pick >= 0) begin m_busy = 1; m_owner = pick; m_beats = 0; end
    end else if (!r[m_owner]) begin
      m_busy = 0; m_last = m_owner;
    end else if (acc) begin
      m_beats++;
      if (m_beats == MB) begin m_busy = 0; m_last = m_owner; end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_a.req = '0; bus_a.req_data = '0; bus_a.fifo_full = 1'b0;
    @(negedge clk);
    check("rst_gnt", bus_a.gnt, 0);
    check("rst_wr", bus_a.fifo_wr, 0);
    @(posedge clk); #1;
    check("rst_busy", bus_a.busy, 0);
    check("rst_owner", bus_a.owner, 0);
    check("rst_state", st_a, IDLE);
    rst = 1'b0;
    model_reset();
    exp_q.delete();
  endtask

  function automatic int gnt_idx(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return -1;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic        full;
    logic [3:0]  gnt;
    logic        wr;
    logic [7:0]  fdata;
    logic        busy;
  } vec_t;

  vec_t vecs[7];

  // producer state for randomized and FIFO tests
  logic [7:0] word [4];
  logic [3:0] has;
  int         rem0, rem1, fifo_cnt, wr_full, g_cnt;
  int         gseq[$];

  initial begin
    bus_b.req = '0; bus_b.req_data = '0; bus_b.fifo_full = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // ---- 1: all requesting, round-robin bursts of 4 with one bubble ----
    gseq.delete(); g_cnt = 0;
    for (int c = 0; c < 25; c++) begin
      cycle(4'b1111, 32'h44332211, 1'b0);
      if (last_gnt != 0) begin
        gseq.push_back(gnt_idx(last_gnt));
        if (c < 20) g_cnt++;
      end
    end
    check("t1_grants_in_20", g_cnt, 16);
    check("t1_grants_in_25", gseq.size(), 20);
    for (int i = 0; i < gseq.size(); i++) check("t1_order", gseq[i], (i / 4) % 4);

    // ---- 2: single requester, table-driven ----
    do_reset();
    vecs[0] = '{4'b0100, 32'h00A50000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{4'b0100, 32'h00A50000, 1'b0, 4'b0100, 1'b1, 8'hA5, 1'b1};
    vecs[2] = '{4'b0100, 32'h003C0000, 1'b0, 4'b0100, 1'b1, 8'h3C, 1'b1};
    vecs[3] = '{4'b0000, 32'h003C0000, 1'b0, 4'b0000, 1'b0, 8'h3C, 1'b1};
    vecs[4] = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{4'b1111, 32'h44A52211, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0};
    vecs[6] = '{4'b1111, 32'h44A52211, 1'b0, 4'b1000, 1'b1, 8'h44, 1'b1};
    for (int i = 0; i < 7; i++) begin
      bus_a.req = vecs[i].req; bus_a.req_data = vecs[i].data; bus_a.fifo_full = vecs[i].full;
      @(negedge clk);
      check("t2_gnt", bus_a.gnt, vecs[i].gnt);
      check("t2_wr", bus_a.fifo_wr, vecs[i].wr);
      check("t2_data", bus_a.fifo_data, vecs[i].fdata);
      check("t2_busy", bus_a.busy, vecs[i].busy);
      @(posedge clk); #1;
    end

    // ---- 3: full stalls owner 1 after two beats ----
    do_reset();
    cycle(4'b0010, 32'h00001100, 1'b0);
    cycle(4'b0010, 32'h00001100, 1'b0);
    check("t3_beat0", last_gnt, 4'b0010);
    cycle(4'b0010, 32'h00001200, 1'b0);
    g_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      cycle(4'b0010, 32'h00001300, 1'b1);
      if (last_gnt != 0 || last_wr) g_cnt++;
    end
    check("t3_stall_writes", g_cnt, 0);
    cycle(4'b0010, 32'h00001300, 1'b0);
    check("t3_beat2", last_gnt, 4'b0010);
    cycle(4'b0010, 32'h00001400, 1'b0);
    check("t3_beat3", last_wr, 1);
    cycle(4'b0010, 32'h00001500, 1'b0);
    check("t3_ended", last_wr, 0);

    // ---- 4: 40 words from two producers into a 32-deep FIFO ----
    do_reset();
    rem0 = 20; rem1 = 20; fifo_cnt = 0; wr_full = 0;
    for (int c = 0; c < 150; c++) begin
      cycle({2'b00, rem1 > 0, rem0 > 0}, {16'h0, 8'(rem1), 8'(rem0)}, fifo_cnt >= 32);
      if (last_wr) begin
        if (fifo_cnt >= 32) wr_full++;
        else fifo_cnt++;
      end
      if (last_gnt[0]) rem0--;
      if (last_gnt[1]) rem1--;
    end
    check("t4_fifo_cnt", fifo_cnt, 32);
    check("t4_wr_while_full", wr_full, 0);
    check("t4_consumed", 40 - rem0 - rem1, 32);

    // ---- 5: reset mid-burst of owner 3 ----
    do_reset();
    cycle(4'b1000, 32'h77000000, 1'b0);
    cycle(4'b1000, 32'h77000000, 1'b0);
    cycle(4'b1000, 32'h78000000, 1'b0);
    rst = 1'b1;
    bus_a.req = 4'b1000; bus_a.req_data = 32'h79000000;
    @(negedge clk);
    check("t5_rst_gnt", bus_a.gnt, 0);
    check("t5_rst_wr", bus_a.fifo_wr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    exp_q.delete();
    check("t5_busy_after", bus_a.busy, 0);
    cycle(4'b1001, 32'h79000055, 1'b0);
    cycle(4'b1001, 32'h79000055, 1'b0);
    check("t5_regrant", last_gnt, 4'b0001);

    // ---- random stimulus vs model ----
    do_reset();
    has = '0;
    for (int i = 0; i < 4; i++) word[i] = 8'($urandom);
    for (int c = 0; c < 400; c++) begin
      cycle(has, {word[3], word[2], word[1], word[0]}, $urandom_range(0, 3) == 0);
      for (int i = 0; i < 4; i++) begin
        if (last_gnt[i]) begin
          word[i] = 8'($urandom);
          has[i]  = $urandom_range(0, 2) != 0;
        end else if (!has[i]) begin
          has[i] = $urandom_range(0, 3) == 0;
        end
      end
    end
    check("rand_sb_empty", exp_q.size(), 0);

    // ---- 6: N_REQ=2, MAX_BURST=1 alternation ----
    @(negedge clk);
    check("t6_rst_busy", bus_b.busy, 0);
    @(posedge clk); #1;
    rst_b = 1'b0;
    bus_b.req = 2'b11; bus_b.req_data = 16'hBBAA;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("t6_gnt", bus_b.gnt, (c % 2 == 0) ? 2'b00 : ((c % 4 == 1) ? 2'b01 : 2'b10));
      if (c % 2 == 1) check("t6_data", bus_b.fifo_data, (c % 4 == 1) ? 8'hAA : 8'hBB);
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
